// File: rtl/imem_loader.sv
// Streams a program into instruction memory over a byte valid/ready handshake, packing
// bytes big-endian into 32-bit words and holding the CPU in reset for the whole load.
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W:0]   WordCount,
    input  logic [7:0]        ByteIn,
    input  logic              ByteValid,
    output logic              ByteReady,
    output logic              ImWe,
    output logic [ADDR_W-1:0] ImWAdr,
    output logic [31:0]       ImWData,
    output logic              CpuHold,
    output logic              Done,
    output logic              Err,
    output logic [31:0]       Checksum
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W-1:0] index_reg;
    logic [1:0]        byte_cnt_reg;
    logic [31:0]       word_reg;
    logic [31:0]       checksum_reg;
    logic              err_reg;

    logic idle_like, start_ok, start_bad, xfer, last_word;

    assign idle_like = (state_reg == IDLE) || (state_reg == DONE);
    assign start_ok  = idle_like && Start && (WordCount != '0) && (WordCount <= MAX_COUNT);
    assign start_bad = idle_like && Start && !((WordCount != '0) && (WordCount <= MAX_COUNT));
    assign xfer      = (state_reg == RECV) && ByteValid;
    assign last_word = ({1'b0, index_reg} == (count_reg - ONE));

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_next = RECV;
                end else if (start_bad) begin
                    state_next = IDLE;
                end
            end
            RECV: begin
                if (xfer && (byte_cnt_reg == 2'd3)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = last_word ? DONE : RECV;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ByteReady = (state_reg == RECV);
        ImWe      = (state_reg == WRITE);
        CpuHold   = (state_reg == RECV) || (state_reg == WRITE);
        Done      = (state_reg == DONE);
        Err       = err_reg;
        ImWAdr    = index_reg;
        ImWData   = word_reg;
        Checksum  = checksum_reg;
    end

    // Datapath: index and word register persist through DONE so the last write stays visible.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            count_reg    <= '0;
            index_reg    <= '0;
            byte_cnt_reg <= '0;
            word_reg     <= '0;
            checksum_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (start_ok) begin
                count_reg    <= WordCount;
                index_reg    <= '0;
                byte_cnt_reg <= '0;
                word_reg     <= '0;
                checksum_reg <= '0;
                err_reg      <= 1'b0;
            end else if (start_bad) begin
                err_reg <= 1'b1;
            end

            if (xfer) begin
                case (byte_cnt_reg)
                    2'd0:    word_reg[31:24] <= ByteIn;
                    2'd1:    word_reg[23:16] <= ByteIn;
                    2'd2:    word_reg[15:8]  <= ByteIn;
                    default: word_reg[7:0]   <= ByteIn;
                endcase
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end

            if (state_reg == WRITE) begin
                checksum_reg <= checksum_reg + word_reg;
                if (!last_word) begin
                    index_reg <= index_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: IM is shadowed from the write port and compared with
// hand-computed words, checksums, addresses and cycle offsets.
module tb_imem_loader;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [5:0]  WordCount;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        ImWe;
    logic [4:0]  ImWAdr;
    logic [31:0] ImWData;
    logic        CpuHold;
    logic        Done;
    logic        Err;
    logic [31:0] Checksum;

    imem_loader #(.ADDR_W(5), .DEPTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .WordCount(WordCount),
        .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
        .ImWe(ImWe), .ImWAdr(ImWAdr), .ImWData(ImWData), .CpuHold(CpuHold),
        .Done(Done), .Err(Err), .Checksum(Checksum)
    );

    localparam logic [31:0] MARK = 32'hDEADBEEF;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          writes = 0;
    int          xfers = 0;
    int          first_xfer = -1;
    int          start_cyc = 0;
    int          write_cyc[$];
    int          write_adr[$];
    logic [31:0] im [0:31];
    logic [7:0]  q[$];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    // Shadow IM: capture each write strobe mid-cycle.
    always @(negedge Clk) begin
        if (Reset && ImWe) begin
            im[ImWAdr] = ImWData;
            write_cyc.push_back(cyc);
            write_adr.push_back(int'(ImWAdr));
            if (writes == 0) first_xfer = xfers;
            writes++;
            $display("write adr=%0d data=%h", ImWAdr, ImWData);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) im[i] = MARK;
        write_cyc.delete();
        write_adr.delete();
        writes = 0;
        xfers = 0;
        first_xfer = -1;
    endtask

    task automatic do_start(input logic [5:0] count);
        Start = 1'b1;
        WordCount = count;
        @(posedge Clk); #1;
        Start = 1'b0;
        WordCount = '0;
    endtask

    task automatic feed(input logic [7:0] b[$], input bit toggle);
        int   i = 0;
        int   n = 0;
        logic rdy;
        while (i < b.size() && n < 1000) begin
            ByteValid = !(toggle && (n % 2 == 1));
            ByteIn = b[i];
            rdy = ByteReady;
            @(posedge Clk); #1;
            if (rdy && ByteValid) begin
                i++;
                xfers++;
            end
            n++;
        end
        ByteValid = 1'b0;
        check("feed_bytes", i, b.size());
    endtask

    task automatic wait_done();
        int n = 0;
        while (!Done && n < 500) begin
            @(posedge Clk); #1;
            n++;
        end
        check("done_wait", {31'b0, Done}, 32'd1);
    endtask

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        WordCount = '0;
        ByteIn = '0;
        ByteValid = 1'b0;
        clear_model();

        // 1: reset state
        repeat (2) @(posedge Clk);
        #1;
        check("rst_ready", {31'b0, ByteReady}, 32'd0);
        check("rst_we", {31'b0, ImWe}, 32'd0);
        check("rst_hold", {31'b0, CpuHold}, 32'd0);
        check("rst_done", {31'b0, Done}, 32'd0);
        check("rst_err", {31'b0, Err}, 32'd0);
        check("rst_adr", {27'b0, ImWAdr}, 32'd0);
        check("rst_data", ImWData, 32'd0);
        check("rst_csum", Checksum, 32'd0);
        Reset = 1'b1;
        @(posedge Clk); #1;

        // 2: two-word load, ByteValid held high
        q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h01, 8'h00, 8'h04};
        do_start(6'd2);
        start_cyc = cyc;
        check("t2_hold", {31'b0, CpuHold}, 32'd1);
        feed(q, 1'b0);
        wait_done();
        check("t2_writes", writes, 32'd2);
        check("t2_im0", im[0], 32'h20080005);
        check("t2_im1", im[1], 32'h8C010004);
        check("t2_cyc0", write_cyc[0] - start_cyc, 32'd4);
        check("t2_cyc1", write_cyc[1] - start_cyc, 32'd9);
        check("t2_csum", Checksum, 32'hAC090009);
        check("t2_hold_done", {31'b0, CpuHold}, 32'd0);
        check("t2_adr_hold", {27'b0, ImWAdr}, 32'd1);
        check("t2_data_hold", ImWData, 32'h8C010004);

        // 3: same load, ByteValid toggling
        clear_model();
        do_start(6'd2);
        check("t3_done_clr", {31'b0, Done}, 32'd0);
        feed(q, 1'b1);
        wait_done();
        check("t3_writes", writes, 32'd2);
        check("t3_im0", im[0], 32'h20080005);
        check("t3_im1", im[1], 32'h8C010004);
        check("t3_csum", Checksum, 32'hAC090009);
        check("t3_first_xfer", first_xfer, 32'd4);

        // 4: illegal counts, then a legal one clears Err
        clear_model();
        do_start(6'd0);
        check("t4_err0", {31'b0, Err}, 32'd1);
        check("t4_done0", {31'b0, Done}, 32'd0);
        check("t4_hold0", {31'b0, CpuHold}, 32'd0);
        do_start(6'd33);
        check("t4_err33", {31'b0, Err}, 32'd1);
        check("t4_ready33", {31'b0, ByteReady}, 32'd0);
        repeat (3) @(posedge Clk);
        #1;
        check("t4_nowrite", writes, 32'd0);
        do_start(6'd1);
        check("t4_err_clr", {31'b0, Err}, 32'd0);
        q = '{8'h12, 8'h34, 8'h56, 8'h78};
        feed(q, 1'b0);
        wait_done();
        check("t4_im0", im[0], 32'h12345678);
        check("t4_csum", Checksum, 32'h12345678);

        // 5: full-depth load of 0xFF bytes
        clear_model();
        q.delete();
        for (int i = 0; i < 128; i++) q.push_back(8'hFF);
        do_start(6'd32);
        feed(q, 1'b0);
        wait_done();
        repeat (4) @(posedge Clk);
        #1;
        check("t5_writes", writes, 32'd32);
        for (int i = 0; i < 32 && i < write_adr.size(); i++) begin
            check($sformatf("t5_adr%0d", i), write_adr[i], i);
        end
        check("t5_csum", Checksum, 32'hFFFFFFE0);
        check("t5_last_adr", {27'b0, ImWAdr}, 32'd31);

        // 6: reset after 6 bytes of a 2-word load; mid-RECV Start ignored
        clear_model();
        q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        do_start(6'd2);
        feed(q, 1'b0);
        do_start(6'd1);
        check("t6_ignore_ready", {31'b0, ByteReady}, 32'd1);
        check("t6_ignore_adr", {27'b0, ImWAdr}, 32'd1);
        check("t6_ignore_csum", Checksum, 32'hA1B2C3D4);
        q = '{8'hF6};
        feed(q, 1'b0);
        check("t6_hold_pre", {31'b0, CpuHold}, 32'd1);
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("t6_hold_rst", {31'b0, CpuHold}, 32'd0);
        check("t6_ready_rst", {31'b0, ByteReady}, 32'd0);
        check("t6_done_rst", {31'b0, Done}, 32'd0);
        check("t6_csum_rst", Checksum, 32'd0);
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("t6_writes", writes, 32'd1);
        check("t6_im0", im[0], 32'hA1B2C3D4);
        check("t6_im1", im[1], MARK);
        check("t6_done", {31'b0, Done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
